lower_part_or_borrow_lookahead_subtractor: RTL and testbench

Pipelined approximate subtractor that computes `min_i - sub_i` as `min_i + ~sub_i`.
- Low `APPROX_WIDTH` bits use an OR-based approximation.
- Upper bits use an exact lookahead carry chain; the borrow is the inverted carry.
- It is the subtraction counterpart to the lower-part-OR lookahead adder family and is used wherever datapaths need approximate differences, such as error/residual computation.
- Two-stage valid/ready pipeline with full throughput under backpressure.

---
 rtl/lower_part_or_borrow_lookahead_subtractor.sv | 120 ++++++++++++
 tb/tb_lower_part_or_borrow_lookahead_subtractor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lower_part_or_borrow_lookahead_subtractor.sv
// Two-stage approximate subtractor: min - sub computed as min + ~sub, with an
// OR-approximated low part and an exact carry-lookahead upper part.
module lower_part_or_borrow_lookahead_subtractor #(
    parameter int WIDTH        = 16,
    parameter int APPROX_WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] sub_i,
    input  logic             borrow_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH:0]   result_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam int UW = WIDTH - APPROX_WIDTH;

    logic [WIDTH-1:0] b_next;
    logic [UW-1:0]    p_next;
    logic [UW-1:0]    g_next;
    logic [UW-1:0]    x_next;
    logic             c_l_next;

    logic             adv1;
    logic             adv2;

    logic             s1_valid_reg;
    logic             s1_c_reg;
    logic [UW-1:0]    s1_p_reg;
    logic [UW-1:0]    s1_g_reg;
    logic [UW-1:0]    s1_x_reg;

    logic [UW:0]      carry;
    logic [UW-1:0]    diff_hi;
    logic [WIDTH-1:0] diff_next;

    logic             s2_valid_reg;
    logic [WIDTH:0]   s2_result_reg;

    assign b_next = ~sub_i;

    // Stage 1: per-bit propagate / generate / half-sum of the upper part
    generate
        for (genvar gi = 0; gi < UW; gi++) begin : gen_pgx
            assign p_next[gi] = min_i[APPROX_WIDTH+gi] | b_next[APPROX_WIDTH+gi];
            assign g_next[gi] = min_i[APPROX_WIDTH+gi] & b_next[APPROX_WIDTH+gi];
            assign x_next[gi] = min_i[APPROX_WIDTH+gi] ^ b_next[APPROX_WIDTH+gi];
        end
    endgenerate

    // Low part and carry seed depend on whether any bits are approximated
    generate
        if (APPROX_WIDTH > 0) begin : gen_approx
            logic [APPROX_WIDTH-1:0] s1_low_reg;
            logic                    unused_borrow;

            assign unused_borrow = borrow_i;
            // The two's-complement +1 is intentionally dropped here
            assign c_l_next = min_i[APPROX_WIDTH-1] & b_next[APPROX_WIDTH-1];

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    s1_low_reg <= '0;
                end else if (adv1) begin
                    s1_low_reg <= min_i[APPROX_WIDTH-1:0] | b_next[APPROX_WIDTH-1:0];
                end
            end

            assign diff_next = {diff_hi, s1_low_reg};
        end else begin : gen_exact
            assign c_l_next  = ~borrow_i;
            assign diff_next = diff_hi;
        end
    endgenerate

    assign adv2    = ~s2_valid_reg | ready_i;
    assign adv1    = ~s1_valid_reg | adv2;
    assign ready_o = adv1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid_reg <= 1'b0;
            s1_c_reg     <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s1_x_reg     <= '0;
        end else if (adv1) begin
            s1_valid_reg <= valid_i;
            s1_c_reg     <= c_l_next;
            s1_p_reg     <= p_next;
            s1_g_reg     <= g_next;
            s1_x_reg     <= x_next;
        end
    end

    // Stage 2: resolve the carry chain from the registered p/g terms
    assign carry[0] = s1_c_reg;
    generate
        for (genvar gi = 0; gi < UW; gi++) begin : gen_chain
            assign carry[gi+1] = s1_g_reg[gi] | (s1_p_reg[gi] & carry[gi]);
            assign diff_hi[gi] = s1_x_reg[gi] ^ carry[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
        end else if (adv2) begin
            s2_valid_reg  <= s1_valid_reg;
            s2_result_reg <= {~carry[UW], diff_next};
        end
    end

    assign valid_o  = s2_valid_reg;
    assign result_o = s2_result_reg;

endmodule

// File: tb/tb_lower_part_or_borrow_lookahead_subtractor.sv
// Bench for the approximate (16/4) and exact (16/0) subtractor variants driven
// in lockstep, checked against arithmetic reference models and a FIFO scoreboard.
module tb_lower_part_or_borrow_lookahead_subtractor;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [15:0] min_i;
    logic [15:0] sub_i;
    logic        borrow_i;
    logic        valid_i;
    logic        ready_i;

    logic        ready_o_a, valid_a;
    logic [16:0] result_a;
    logic        ready_o_e, valid_e;
    logic [16:0] result_e;

    always #5 clk = ~clk;

    lower_part_or_borrow_lookahead_subtractor #(.WIDTH(16), .APPROX_WIDTH(4)) dut_apx (
        .clk_i    (clk),
        .reset_n_i(reset_n_i),
        .min_i    (min_i),
        .sub_i    (sub_i),
        .borrow_i (borrow_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o_a),
        .result_o (result_a),
        .valid_o  (valid_a),
        .ready_i  (ready_i)
    );

    lower_part_or_borrow_lookahead_subtractor #(.WIDTH(16), .APPROX_WIDTH(0)) dut_exa (
        .clk_i    (clk),
        .reset_n_i(reset_n_i),
        .min_i    (min_i),
        .sub_i    (sub_i),
        .borrow_i (borrow_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o_e),
        .result_o (result_e),
        .valid_o  (valid_e),
        .ready_i  (ready_i)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_out    = 0;
    logic [16:0] exp_a_q[$];
    logic [16:0] exp_e_q[$];
    logic        hold_pending = 1'b0;
    logic [16:0] held_a, held_e;
    logic        last_ready, last_accept;
    logic        thru_chk = 1'b0;

    // Approximate model: OR the low nibble, add the upper fields with plain arithmetic
    function automatic logic [16:0] model_apx(input logic [15:0] m, input logic [15:0] s);
        logic [15:0] b;
        logic [3:0]  low;
        logic        cl;
        logic [12:0] hi;
        b   = ~s;
        low = m[3:0] | b[3:0];
        cl  = m[3] & b[3];
        hi  = {1'b0, m[15:4]} + {1'b0, b[15:4]} + {12'd0, cl};
        return {~hi[12], hi[11:0], low};
    endfunction

    // Exact model: true difference; a negative result sets bit 16 as the borrow
    function automatic logic [16:0] model_exa(input logic [15:0] m, input logic [15:0] s, input logic bi);
        return {1'b0, m} - {1'b0, s} - {16'd0, bi};
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, sample 1 time unit later, scoreboard both handshakes
    task automatic cycle(input logic v, input logic [15:0] m, input logic [15:0] s,
                         input logic bi, input logic rdy, input logic dir,
                         input logic [16:0] da, input logic [16:0] de);
        logic [16:0] ea, ee;
        @(negedge clk);
        valid_i  = v;
        min_i    = m;
        sub_i    = s;
        borrow_i = bi;
        ready_i  = rdy;
        #1;
        if (hold_pending) begin
            chk("hold_a", result_a, held_a);
            chk("hold_e", result_e, held_e);
        end
        if (thru_chk && ready_i) chk("thru_ready", {16'd0, ready_o_a}, 17'd1);
        if (valid_a && ready_i) begin
            chk("valid_e", {16'd0, valid_e}, 17'd1);
            if (exp_a_q.size() == 0) begin
                chk("spurious_valid", {16'd0, valid_a}, 17'd0);
            end else begin
                ea = exp_a_q.pop_front();
                ee = exp_e_q.pop_front();
                chk("result_apx", result_a, ea);
                chk("result_exa", result_e, ee);
                $display("out #%0d apx=%h exa=%h", n_out, result_a, result_e);
            end
            n_out++;
        end
        hold_pending = valid_a && !ready_i;
        held_a       = result_a;
        held_e       = result_e;
        last_ready   = ready_o_a;
        last_accept  = valid_i && ready_o_a;
        if (last_accept) begin
            exp_a_q.push_back(dir ? da : model_apx(m, s));
            exp_e_q.push_back(dir ? de : model_exa(m, s, bi));
            $display("in  min=%h sub=%h bin=%0d", m, s, bi);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, rdy, 1'b0, 17'd0, 17'd0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_a_q.size() != 0 && n < bound) begin
            idle(1'b1);
            n++;
        end
        chk("drain_left", 17'(exp_a_q.size()), 17'd0);
    endtask

    initial begin
        int          acc;
        int          cyc;
        int          out0;
        logic [15:0] m, s;
        logic        bi;

        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        min_i     = '0;
        sub_i     = '0;
        borrow_i  = 1'b0;
        #3;
        chk("rst_valid_a", {16'd0, valid_a}, 17'd0);
        chk("rst_result_a", result_a, 17'd0);
        chk("rst_ready_a", {16'd0, ready_o_a}, 17'd1);
        chk("rst_valid_e", {16'd0, valid_e}, 17'd0);
        chk("rst_result_e", result_e, 17'd0);
        chk("rst_ready_e", {16'd0, ready_o_e}, 17'd1);
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;

        // Latency: lone operand shows up on valid_o two edges after it is driven
        cycle(1'b1, 16'h1234, 16'h0011, 1'b0, 1'b1, 1'b1, 17'h0121E, 17'h01223);
        #1 chk("latency_1", {16'd0, valid_a}, 17'd0);
        idle(1'b1);
        #1 chk("latency_2", {16'd0, valid_a}, 17'd1);
        drain(10);

        // Directed values, back to back
        cycle(1'b1, 16'h1234, 16'h0011, 1'b1, 1'b1, 1'b1, 17'h0121E, 17'h01222);
        cycle(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1, 17'h1FFFE, 17'h1FFFF);
        cycle(1'b1, 16'h00F0, 16'h00F0, 1'b0, 1'b1, 1'b1, 17'h1FFFF, 17'h00000);
        drain(10);

        // Backpressure: two accepted, third refused, outputs held, then all emerge in order
        out0 = n_out;
        cycle(1'b1, 16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b0, 17'd0, 17'd0);
        chk("bp_ready_1", {16'd0, last_ready}, 17'd1);
        cycle(1'b1, 16'h0F0F, 16'h7777, 1'b1, 1'b0, 1'b0, 17'd0, 17'd0);
        chk("bp_ready_2", {16'd0, last_ready}, 17'd1);
        cycle(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17'd0, 17'd0);
        chk("bp_ready_3", {16'd0, last_ready}, 17'd0);
        cycle(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17'd0, 17'd0);
        chk("bp_ready_4", {16'd0, last_ready}, 17'd0);
        cyc = 0;
        last_accept = 1'b0;
        while (!last_accept && cyc < 10) begin
            cycle(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 17'd0, 17'd0);
            cyc++;
        end
        chk("bp_third_accepted", {16'd0, last_accept}, 17'd1);
        drain(10);
        chk("bp_out_count", 17'(n_out - out0), 17'd3);

        // Reset with two operations in flight
        cycle(1'b1, 16'h4321, 16'h0123, 1'b0, 1'b0, 1'b0, 17'd0, 17'd0);
        cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 17'd0, 17'd0);
        @(negedge clk);
        valid_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_valid_a", {16'd0, valid_a}, 17'd0);
        chk("mid_rst_result_a", result_a, 17'd0);
        chk("mid_rst_ready_a", {16'd0, ready_o_a}, 17'd1);
        chk("mid_rst_valid_e", {16'd0, valid_e}, 17'd0);
        chk("mid_rst_result_e", result_e, 17'd0);
        exp_a_q.delete();
        exp_e_q.delete();
        hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            #1 chk("no_stale", {16'd0, valid_a}, 17'd0);
        end

        // Streaming: 100 operands with random backpressure
        acc = 0;
        cyc = 0;
        m   = 16'($urandom);
        s   = 16'($urandom);
        bi  = 1'($urandom);
        thru_chk = 1'b1;
        while (acc < 100 && cyc < 2000) begin
            cycle(1'b1, m, s, bi, 1'($urandom), 1'b0, 17'd0, 17'd0);
            cyc++;
            if (last_accept) begin
                acc++;
                m  = 16'($urandom);
                s  = 16'($urandom);
                bi = 1'($urandom);
            end
        end
        thru_chk = 1'b0;
        chk("stream_accepts", 17'(acc), 17'd100);
        drain(20);

        // Random sweep, full throughput
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0, 17'd0, 17'd0);
        end
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
